regbank_write: RTL and testbench
================================

Name: regbank_write

Overview:
- Write side of the register bank: the counterpart of the 32:1 read-select tree.
- Decodes a 5-bit write address into a one-hot enable and stores write data into 32 registers. Register 0 is hardwired to zero.
- Exposes all register contents flattened, so the read-port multiplexer trees can select from them.
- Sits in the MIPS datapath at the write-back stage. Driven by the control unit's RegWrite and the write-back address/data.

Parameters:
- WIDTH, 32, data bits per register.
- NREGS, 32, number of registers; must equal 2**AW.
- AW, 5, write-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write enable (RegWrite).
- wa  in  AW  write address.
- wd  in  WIDTH  write data.
- q  out  NREGS*WIDTH  flattened contents; register i occupies bits [i*WIDTH +: WIDTH].
- wen  out  NREGS  decoded one-hot write enable, combinational; bit 0 always 0.
- fwd_valid  out  1  a buffered write is pending (WRITE_BUFFER_EN only, else constant 0).
- fwd_addr  out  AW  address of the pending write (else 0).
- fwd_data  out  WIDTH  data of the pending write (else 0).
- wz_err  out  1  sticky flag: a write to register 0 was attempted.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset (sampled high at an edge):
  - All registers clear to 0, so q = 0.
  - wz_err, fwd_valid, fwd_addr and fwd_data clear to 0.
  - Reset has priority over any write in the same cycle.
- Decode: wen[i] = we && (wa == i) for i = 1..NREGS-1; wen[0] = 0.
- Write latency (no macro): with we=1 and wa=k (k≠0) at edge N, register k = wd after edge N. Only register k changes; all others hold.
- Register 0: always reads 0 and is never stored.
  - A write with we=1 and wa=0 changes no register.
  - That write sets wz_err at the edge; wz_err stays set until reset.
- we=0: no register changes and wz_err is unaffected, whatever wa and wd hold.
- Back-to-back writes to the same address: the last one wins, and each takes effect at its own edge.
- Reset mid-write: the write is discarded and the register reads 0.
- Storage has no read-during-write bypass. q shows the old value until the edge; forwarding is the reader's concern.

Optional Feature:
- Macro: REGBANK_WRITE_BUFFER_EN.
- Defined: a one-entry write buffer is inserted to cut the write-back-to-storage timing path.
  - Edge N: the request (we, wa, wd) is captured into the buffer. fwd_valid=we && wa≠0, fwd_addr=wa, fwd_data=wd.
  - Edge N+1: the buffered entry commits into storage. Total write latency is 2 edges.
  - A new request at edge N+1 overwrites the buffer while the old entry commits. There is no stall and no loss.
  - Two consecutive writes to the same address commit in order.
  - Readers must check fwd_* to see the uncommitted value.
  - wz_err is still set at edge N.
  - Reset clears the buffer without committing it.
- Undefined: 1-edge write latency; fwd_* tied to 0.

Decomposition:
- Package regbank_pkg:
  - constants WIDTH=32, NREGS=32, AW=5;
  - typedef word_t (logic [WIDTH-1:0]);
  - typedef regaddr_t (logic [AW-1:0]).
- Sub-module decoder5: 5-to-32 one-hot decoder with an enable input. Instantiated once; bit 0 is masked in regbank_write. It mirrors the read tree's mux structure on the write side.

Test Plan:
- Reset, then we=1, wa=3, wd=0xDEADBEEF for one cycle -> next cycle q[3]=0xDEADBEEF, all other registers 0, wen=0x00000008 during the write cycle.
- we=1, wa=0, wd=0xFFFFFFFF -> q[0] stays 0, wz_err=1 and stays 1 for 10 idle cycles until reset clears it.
- Write wa=7 with 0x11 then 0x22 on consecutive edges -> q[7]=0x11 after the first edge, 0x22 after the second. No other register changes.
- we=0 with wa=5, wd=0x1234 for 5 cycles -> q unchanged, wen=0.
- Write wa=9 with 0xA5A5A5A5 with reset asserted in the same cycle -> q[9]=0, all outputs 0.
- REGBANK_WRITE_BUFFER_EN defined, write wa=4 with 0xCAFE -> after edge N fwd_valid=1, fwd_addr=4, fwd_data=0xCAFE, q[4]=0. After edge N+1, q[4]=0xCAFE and fwd_valid=0 (if we=0).

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank write side.
package regbank_pkg;

    localparam int WIDTH = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [AW-1:0]    regaddr_t;

    // One-hot position of a register address.
    function automatic logic [NREGS-1:0] addr_to_onehot(input regaddr_t a);
        logic [NREGS-1:0] one_s;
        one_s = {{(NREGS-1){1'b0}}, 1'b1};
        return one_s << a;
    endfunction

endpackage

// File: rtl/regbank_write_if.sv
// Write-back request bus into the register bank (RegWrite, address, data).
interface regbank_write_if;
    import regbank_pkg::*;

    logic     we;
    regaddr_t wa;
    word_t    wd;

    modport master (output we, output wa, output wd);
    modport slave  (input  we, input  wa, input  wd);

endinterface

// File: rtl/decoder5.sv
// 5-to-32 one-hot decoder with enable; write-side twin of the read mux tree.
module decoder5
    import regbank_pkg::*;
(
    input  logic             i_en,
    input  regaddr_t         i_addr,
    output logic [NREGS-1:0] o_onehot
);

    // Select one line when enabled, all zero otherwise.
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot = addr_to_onehot(i_addr);
        end else begin
            o_onehot = '0;
        end
    end

endmodule

// File: rtl/regbank_write.sv
// Register-bank write side: decode, 31 storage registers (r0 hardwired to 0).
// Optional one-entry write buffer selected by macro REGBANK_WRITE_BUFFER_EN.
module regbank_write
    import regbank_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    regbank_write_if.slave         bus,
    output logic [NREGS*WIDTH-1:0] q,
    output logic [NREGS-1:0]       wen,
    output logic                   fwd_valid,
    output regaddr_t               fwd_addr,
    output word_t                  fwd_data,
    output logic                   wz_err
);

    logic [NREGS-1:0] w_dec;
    logic [NREGS-1:1] w_commit_wen;
    word_t            w_commit_data;
    word_t            r_regs [1:NREGS-1];
    logic             r_wz_err;
    logic             w_wz_hit;

    decoder5 u_dec (
        .i_en     (bus.we),
        .i_addr   (bus.wa),
        .o_onehot (w_dec)
    );

    // Register 0 is never a write target, so its enable line is masked.
    always_comb begin
        wen = w_dec & ~{{(NREGS-1){1'b0}}, 1'b1};
    end

    assign w_wz_hit = bus.we && (bus.wa == {AW{1'b0}});

`ifdef REGBANK_WRITE_BUFFER_EN
    logic [NREGS-1:1] r_buf_wen;
    regaddr_t         r_buf_addr;
    word_t            r_buf_data;

    // Capture the request this edge; it commits to storage on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_wen  <= '0;
            r_buf_addr <= {AW{1'b0}};
            r_buf_data <= {WIDTH{1'b0}};
        end else begin
            r_buf_wen  <= wen[NREGS-1:1];
            r_buf_addr <= bus.wa;
            r_buf_data <= bus.wd;
        end
    end

    assign w_commit_wen  = r_buf_wen;
    assign w_commit_data = r_buf_data;
    assign fwd_valid     = |r_buf_wen;
    assign fwd_addr      = r_buf_addr;
    assign fwd_data      = r_buf_data;
`else
    assign w_commit_wen  = wen[NREGS-1:1];
    assign w_commit_data = bus.wd;
    assign fwd_valid     = 1'b0;
    assign fwd_addr      = {AW{1'b0}};
    assign fwd_data      = {WIDTH{1'b0}};
`endif

    // Storage: reset wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_commit_wen[i]) begin
                    r_regs[i] <= w_commit_data;
                end
            end
        end
    end

    // Sticky flag for attempted writes to register 0, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wz_err <= 1'b0;
        end else if (w_wz_hit) begin
            r_wz_err <= 1'b1;
        end
    end

    assign wz_err = r_wz_err;

    // Flatten storage; slot 0 is the hardwired zero register.
    always_comb begin
        q = '0;
        for (int i = 1; i < NREGS; i++) begin
            q[i*WIDTH +: WIDTH] = r_regs[i];
        end
    end

endmodule

// File: tb/tb_regbank_write.sv
// Randomized self-checking bench for regbank_write against an array model.
module tb_regbank_write;
    import regbank_pkg::*;

    logic                   clk;
    logic                   reset;
    logic [NREGS*WIDTH-1:0] q;
    logic [NREGS-1:0]       wen;
    logic                   fwd_valid;
    regaddr_t               fwd_addr;
    word_t                  fwd_data;
    logic                   wz_err;

    regbank_write_if bus_if ();

    regbank_write dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if.slave),
        .q         (q),
        .wen       (wen),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .wz_err    (wz_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain array of register values plus pending buffer entry.
    logic [31:0] m_mem [NREGS];
    logic        m_wz;
    logic        m_pv;
    logic [4:0]  m_pa;
    logic [31:0] m_pd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
        if (r) begin
            for (int i = 0; i < NREGS; i++) m_mem[i] = 32'd0;
            m_wz = 1'b0;
            m_pv = 1'b0;
            m_pa = 5'd0;
            m_pd = 32'd0;
        end else begin
`ifdef REGBANK_WRITE_BUFFER_EN
            if (m_pv) m_mem[m_pa] = m_pd;
            m_pv = w && (a != 5'd0);
            m_pa = a;
            m_pd = d;
`else
            if (w && a != 5'd0) m_mem[a] = d;
`endif
            if (w && a == 5'd0) m_wz = 1'b1;
        end
    endtask

    task automatic check_state(input int full);
        for (int i = 0; i < NREGS; i++) begin
            if (full != 0 || i < 12)
                check_val($sformatf("q[%0d]", i), q[i*WIDTH +: WIDTH], m_mem[i]);
        end
        check_val("wz_err", {31'd0, wz_err}, {31'd0, m_wz});
`ifdef REGBANK_WRITE_BUFFER_EN
        check_val("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_pv});
        if (m_pv) begin
            check_val("fwd_addr", {27'd0, fwd_addr}, {27'd0, m_pa});
            check_val("fwd_data", fwd_data, m_pd);
        end
`else
        check_val("fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check_val("fwd_addr", {27'd0, fwd_addr}, 32'd0);
        check_val("fwd_data", fwd_data, 32'd0);
`endif
    endtask

    // One cycle: drive on the falling edge, check wen, clock, then check state.
    task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d, input int full);
        logic [31:0] exp_wen;
        reset     = r;
        bus_if.we = w;
        bus_if.wa = a;
        bus_if.wd = d;
        #1;
        exp_wen = (w && a != 5'd0) ? (32'd1 << a) : 32'd0;
        check_val("wen", wen, exp_wen);
        @(posedge clk);
        model_edge(r, w, a, d);
        @(negedge clk);
        check_state(full);
    endtask

    initial begin
        reset     = 1'b1;
        bus_if.we = 1'b0;
        bus_if.wa = 5'd0;
        bus_if.wd = 32'd0;
        @(negedge clk);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1);
        step(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1);
        step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 5'(i), 32'h0, 0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1);
        step(1'b0, 1'b1, 5'd7, 32'h11, 1);
        step(1'b0, 1'b1, 5'd7, 32'h22, 1);
        step(1'b0, 1'b0, 5'd7, 32'h0, 1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 5'd5, 32'h1234, 0);
        step(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 1);
        step(1'b0, 1'b1, 5'd4, 32'hCAFE, 1);
        step(1'b0, 1'b0, 5'd4, 32'h0, 1);
        step(1'b0, 1'b0, 5'd4, 32'h0, 1);
        for (int n = 0; n < 400; n++) begin
            logic       rr;
            logic       ww;
            logic [4:0] aa;
            rr = ($urandom_range(0, 49) == 0);
            ww = ($urandom_range(0, 3) != 0);
            aa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            step(rr, ww, aa, $urandom, (n % 8 == 0) ? 1 : 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
